// File: rtl/mex_unit_pkg.sv
// Shared RV32 types for the M-extension unit.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [2:0] {
      mul    = 3'b000,
      mulh   = 3'b001,
      mulhsu = 3'b010,
      mulhu  = 3'b011,
      div    = 3'b100,
      divu   = 3'b101,
      rem    = 3'b110,
      remu   = 3'b111
   } mex_funct3_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } mex_state_t;

   localparam int unsigned MEX_ITERATIONS = 32;

   function automatic logic op_signed_a(mex_funct3_t f);
      return f inside {mulh, mulhsu, div, rem};
   endfunction

   function automatic logic op_signed_b(mex_funct3_t f);
      return f inside {mulh, div, rem};
   endfunction

   function automatic rv32i_word twos(rv32i_word x);
      return ~x + 32'd1;
   endfunction

endpackage

// File: rtl/mex_unit_if.sv
// Request/response bundle between the pipeline and the M-extension unit.
interface mex_unit_if;
   import rv32i_types::*;

   logic        start;
   mex_funct3_t funct3;
   rv32i_word   a;
   rv32i_word   b;
   logic        kill;
   logic        busy;
   logic        done;
   rv32i_word   result;

   modport master (
      output start, funct3, a, b, kill,
      input  busy, done, result
   );

   modport slave (
      input  start, funct3, a, b, kill,
      output busy, done, result
   );

endinterface

// File: rtl/mex_unit_divider.sv
// Iterative restoring divider on unsigned magnitudes; also paces the unit.
module mex_divider #(
   parameter int unsigned ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        flush_i,
   input  logic [31:0] dvd_i,
   input  logic [31:0] dvs_i,
   output logic [31:0] quo_o,
   output logic [31:0] rem_o,
   output logic        done_o
);
   localparam int CW = $clog2(ITER + 1);

   logic [31:0]   rem_q, rem_d;
   logic [31:0]   quo_q, quo_d;
   logic [31:0]   dvs_q;
   logic [CW-1:0] cnt_q;
   logic          run_q;
   logic [32:0]   shl;
   logic [32:0]   diff;

   always_comb begin
      shl   = {rem_q, quo_q[31]};
      diff  = shl - {1'b0, dvs_q};
      rem_d = diff[32] ? shl[31:0] : diff[31:0];
      quo_d = {quo_q[30:0], ~diff[32]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (flush_i) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start_i) begin
         rem_q <= '0;
         quo_q <= dvd_i;
         dvs_q <= dvs_i;
         cnt_q <= CW'(ITER);
         run_q <= 1'b1;
      end else if (run_q) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_q - 1'b1;
         run_q <= (cnt_q != CW'(1));
      end
   end

   // High during the cycle whose closing edge performs the last step.
   assign done_o = run_q & (cnt_q == CW'(1));
   assign quo_o  = quo_q;
   assign rem_o  = rem_q;

endmodule

// File: rtl/mex_unit.sv
// RV32 M-extension unit: shift-add multiply, restoring divide,
// fixed latency of MEX_ITERATIONS+1 cycles from accept to done.
module mex_unit #(
   parameter int unsigned MEX_ITERATIONS = 32
) (
   input  logic       clk,
   input  logic       rst,
   mex_unit_if.slave  bus
);
   import rv32i_types::*;

   mex_state_t  state_q;
   logic        busy_q;
   logic        done_q;
   rv32i_word   result_q;
   mex_funct3_t op_q;
   logic        sa_q;
   logic        sb_q;
   logic        bz_q;
   logic        ovf_q;
   rv32i_word   a_q;
   rv32i_word   mcand_q;
   logic [63:0] prod_q, prod_d;
   logic [32:0] psum;

   logic        accept;
   logic        div_done;
   logic        sa_in, sb_in;
   logic        ovf_in;
   rv32i_word   mag_a, mag_b;
   rv32i_word   quo_w, rem_w;
   logic [63:0] prod_s;
   rv32i_word   quo_s, rem_s;
   rv32i_word   res_d;
   logic        done_w;

   assign accept = (state_q == IDLE) & bus.start & ~bus.kill;

   always_comb begin
      sa_in  = op_signed_a(bus.funct3) & bus.a[31];
      sb_in  = op_signed_b(bus.funct3) & bus.b[31];
      mag_a  = sa_in ? twos(bus.a) : bus.a;
      mag_b  = sb_in ? twos(bus.b) : bus.b;
      ovf_in = (bus.funct3 == div || bus.funct3 == rem)
             & (bus.a == 32'h8000_0000)
             & (bus.b == 32'hFFFF_FFFF);
   end

   // Product register holds {accumulator, remaining multiplier bits}.
   always_comb begin
      psum   = {1'b0, prod_q[63:32]} + {1'b0, mcand_q};
      prod_d = prod_q[0] ? {psum, prod_q[31:1]}
                         : {1'b0, prod_q[63:1]};
   end

   mex_divider #(
      .ITER (MEX_ITERATIONS)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .start_i (accept),
      .flush_i (bus.kill),
      .dvd_i   (mag_a),
      .dvs_i   (mag_b),
      .quo_o   (quo_w),
      .rem_o   (rem_w),
      .done_o  (div_done)
   );

   always_comb begin
      prod_s = (sa_q ^ sb_q) ? (~prod_q + 64'd1) : prod_q;
      quo_s  = (sa_q ^ sb_q) ? twos(quo_w) : quo_w;
      rem_s  = sa_q ? twos(rem_w) : rem_w;
      res_d  = prod_s[31:0];
      unique case (op_q)
         mul:                 res_d = prod_s[31:0];
         mulh, mulhsu, mulhu: res_d = prod_s[63:32];
         div, divu: begin
            if (bz_q)       res_d = 32'hFFFF_FFFF;
            else if (ovf_q) res_d = 32'h8000_0000;
            else            res_d = quo_s;
         end
         rem, remu: begin
            if (bz_q)       res_d = a_q;
            else if (ovf_q) res_d = 32'h0000_0000;
            else            res_d = rem_s;
         end
         default: res_d = prod_s[31:0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         op_q     <= mul;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         bz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         a_q      <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= CALC;
                  busy_q  <= 1'b1;
                  op_q    <= bus.funct3;
                  sa_q    <= sa_in;
                  sb_q    <= sb_in;
                  bz_q    <= (bus.b == '0);
                  ovf_q   <= ovf_in;
                  a_q     <= bus.a;
                  mcand_q <= mag_a;
                  prod_q  <= {32'd0, mag_b};
               end
            end
            CALC: begin
               if (bus.kill) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  prod_q <= prod_d;
                  if (div_done) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               if (!bus.kill) result_q <= res_d;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // A flush landing in DONE suppresses the pulse and keeps the old result.
   assign done_w     = done_q & ~bus.kill;
   assign bus.busy   = busy_q;
   assign bus.done   = done_w;
   assign bus.result = done_w ? res_d : result_q;

endmodule

// File: tb/tb_mex_unit.sv
// Directed and randomized checks of mex_unit against an arithmetic model.
module tb_mex_unit;
   import rv32i_types::*;

   logic clk = 1'b0;
   logic rst;

   mex_unit_if bus ();

   mex_unit #(
      .MEX_ITERATIONS (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_res;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(mex_funct3_t f, logic [31:0] x,
                                         logic [31:0] y);
      logic [63:0] xs, xu, ys, yu, p;
      logic [31:0] r;
      xs = {{32{x[31]}}, x};
      xu = {32'd0, x};
      ys = {{32{y[31]}}, y};
      yu = {32'd0, y};
      p  = '0;
      r  = '0;
      case (f)
         mul:    begin p = xu * yu; r = p[31:0];  end
         mulh:   begin p = xs * ys; r = p[63:32]; end
         mulhsu: begin p = xs * yu; r = p[63:32]; end
         mulhu:  begin p = xu * yu; r = p[63:32]; end
         div: begin
            if (y == 0) r = 32'hFFFF_FFFF;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
            else r = $signed(x) / $signed(y);
         end
         divu: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
         rem: begin
            if (y == 0) r = x;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 0;
            else r = $signed(x) % $signed(y);
         end
         remu: r = (y == 0) ? x : x % y;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Called at a falling edge; returns at the falling edge one cycle later.
   task automatic go(input mex_funct3_t f, input logic [31:0] x,
                     input logic [31:0] y);
      logic [2:0] t;
      bus.funct3 = f;
      bus.a      = x;
      bus.b      = y;
      bus.start  = 1'b1;
      @(negedge clk);
      t          = 3'($urandom_range(0, 7));
      bus.start  = 1'b0;
      bus.funct3 = mex_funct3_t'(t);
      bus.a      = $urandom;
      bus.b      = $urandom;
   endtask

   task automatic run_op(input string tag, input mex_funct3_t f,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input bit poke);
      int cyc;
      int extra;
      bit busy_ok;
      go(f, x, y);
      cyc     = 1;
      busy_ok = 1'b1;
      while (bus.done !== 1'b1 && cyc < 40) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (poke && cyc == 5) bus.start = 1'b1;
         if (poke && cyc == 6) bus.start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'd33);
      check({tag, "_busy_calc"}, 32'(busy_ok), 32'd1);
      check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
      check({tag, "_result"}, bus.result, exp);
      @(negedge clk);
      check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_held"}, bus.result, exp);
      last_res = exp;
      if (poke) begin
         extra = 0;
         repeat (36) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
            @(negedge clk);
         end
         check({tag, "_no_queue"}, 32'(extra), 32'd0);
      end
   endtask

   initial begin
      int seen;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.kill   = 1'b0;
      bus.funct3 = mul;
      bus.a      = '0;
      bus.b      = '0;
      last_res   = '0;
      #1;
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_result", bus.result, 32'd0);

      @(negedge clk);
      rst = 1'b0;
      run_op("mul", mul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      run_op("mulh", mulh, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
      run_op("mulhu", mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_op("mulhsu", mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("div", div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      run_op("rem", rem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
      run_op("divu", divu, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0);
      run_op("remu", remu, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 1'b0);
      run_op("div_by0", div, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
      run_op("remu_by0", remu, 32'd5, 32'd0, 32'h0000_0005, 1'b0);
      run_op("div_ovf", div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      run_op("rem_ovf", rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      run_op("busy_start", mulhu, 32'h1234_5678, 32'h9ABC_DEF0,
             32'h0B00_EA4E, 1'b1);

      go(mul, 32'd3, 32'd5);
      repeat (9) @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      check("kill_busy", 32'(bus.busy), 32'd0);
      seen = 0;
      repeat (40) begin
         if (bus.done === 1'b1) seen++;
         @(negedge clk);
      end
      check("kill_no_done", 32'(seen), 32'd0);
      check("kill_result", bus.result, last_res);
      run_op("after_kill", divu, 32'd1000, 32'd7, 32'd142, 1'b0);

      go(mul, 32'd6, 32'd7);
      repeat (32) @(negedge clk);
      check("done_cycle", 32'(bus.done), 32'd1);
      bus.kill = 1'b1;
      #1;
      check("kill_in_done", 32'(bus.done), 32'd0);
      check("kill_in_done_res", bus.result, last_res);
      @(negedge clk);
      bus.kill = 1'b0;
      check("kill_done_busy", 32'(bus.busy), 32'd0);
      check("kill_done_held", bus.result, last_res);

      bus.start = 1'b1;
      bus.kill  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      check("kill_start_idle", 32'(bus.busy), 32'd0);

      for (int i = 0; i < 40; i++) begin
         mex_funct3_t f;
         logic [2:0] t;
         logic [31:0] x, y;
         t = 3'($urandom_range(0, 7));
         f = mex_funct3_t'(t);
         x = pick();
         y = pick();
         run_op($sformatf("rand%0d_%s", i, f.name()), f, x, y,
                model(f, x, y), (i % 10) == 4);
      end

      go(mulhu, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      repeat (14) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_done", 32'(bus.done), 32'd0);
      check("rst_mid_result", bus.result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (40) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
         @(negedge clk);
      end
      check("rst_no_done", 32'(seen), 32'd0);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst", rem, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mex_unit.md
MEX_UNIT -- requirements
Module: mex_unit

Interface
REQ-001 SHALL declare parameter MEX_ITERATIONS, default 32, meaning the number of iteration cycles per operation (fixed, not user-tuned).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request valid; sampled only while busy=0.
REQ-005 SHALL have port funct3  input  3  operation, encoded as mex_funct3_t (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
REQ-006 SHALL have port a  input  32  rs1 operand (rv32i_word).
REQ-007 SHALL have port b  input  32  rs2 operand (rv32i_word).
REQ-008 SHALL have port kill  input  1  abort the in-flight operation (pipeline flush).
REQ-009 SHALL have port busy  output  1  an operation is in flight.
REQ-010 SHALL have port done  output  1  single-cycle pulse; result valid in that cycle.
REQ-011 SHALL have port result  output  32  operation result.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE.
- IDLE to CALC on start=1 and kill=0.
- CALC to DONE after MEX_ITERATIONS cycles.
- DONE to IDLE unconditionally.
REQ-013 SHALL latch funct3, a and b at the accepting edge; operand changes afterwards SHALL have no effect.
REQ-014 SHALL assert busy in CALC and DONE, and deassert it in IDLE.
REQ-015 SHALL assert done only in DONE, exactly 33 cycles after the accepting cycle, for every funct3 and every operand value, including the special cases below.
REQ-016 SHALL ignore start while busy=1; no queuing.
REQ-017 SHALL compute multiplies by 32-step shift-add on operand magnitudes, then conditionally negate the 64-bit product.
- mul: low 32 bits.
- mulh: high 32 bits, signed x signed.
- mulhsu: high 32 bits, signed a x unsigned b.
- mulhu: high 32 bits, unsigned x unsigned.
REQ-018 SHALL compute divides by 32-step restoring division on magnitudes.
- Quotient is negative iff the operand signs differ (div).
- Remainder takes the dividend's sign (rem).
- divu and remu are unsigned.
REQ-019 SHALL handle divide by zero (b=0) as follows:
- div and divu return 0xFFFFFFFF.
- rem and remu return a.
REQ-020 SHALL handle signed overflow (a=0x80000000, b=0xFFFFFFFF) as follows:
- div returns 0x80000000.
- rem returns 0x00000000.
REQ-021 SHALL hold result at its last produced value until the next DONE.
REQ-022 SHALL treat kill=1 in CALC or DONE as follows:
- Next state is IDLE.
- done is not asserted (a kill in DONE forces done low in that cycle).
- result is unchanged.
REQ-023 SHALL give kill priority when kill=1 and start=1 coincide in IDLE; the request is not accepted.
REQ-024 SHALL accept a new start in the first IDLE cycle after DONE or after a kill.

Reset
REQ-025 SHALL, on rst=1, immediately and without a clock edge, set state=IDLE, busy=0, done=0, result=0x00000000, and clear all internal registers.
REQ-026 SHALL, on rst asserted mid-operation, discard the operation with no later done.
REQ-027 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-028 SHALL place mex_state_t (IDLE, CALC, DONE) and the constant MEX_ITERATIONS=32 in package rv32i_types, alongside the existing mex_funct3_t.
REQ-029 SHALL instantiate sub-module mex_divider (iterative restoring divider core, with start, count and done), with multiply, sign fix-up and special cases in mex_unit.

Verification
REQ-030 SHALL cover mul a=7, b=0xFFFFFFFD -> result=0xFFFFFFEB, with done exactly 33 cycles after start and busy high throughout.
REQ-031 SHALL cover the high-half multiplies:
- mulh 0x80000000 x 0x80000000 -> 0x40000000.
- mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 SHALL cover the divides:
- div -7/2 -> 0xFFFFFFFD.
- rem -7,2 -> 0xFFFFFFFF.
- divu 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- remu 0xFFFFFFF9,2 -> 0x00000001.
REQ-033 SHALL cover the special cases, each with 33-cycle latency:
- div 5/0 -> 0xFFFFFFFF.
- remu 5,0 -> 0x00000005.
- div 0x80000000/0xFFFFFFFF -> 0x80000000.
- rem same operands -> 0x00000000.
REQ-034 SHALL cover kill and start-while-busy:
- kill 10 cycles after start -> busy=0 next cycle, no done, result unchanged.
- start during busy -> ignored.
- start after kill -> accepted, correct result.
REQ-035 SHALL cover rst asserted mid-CALC between clock edges -> busy, done and result read 0 before the next edge, with no done afterwards.
